// File: rtl/ir_command_regs_if.sv
// Processor bus bundle for the IR command register block.
// The processor side drives master; the peripheral uses slave.
interface ir_command_regs_if;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA_IN;
    logic       BUS_WE;
    logic [7:0] BUS_DATA_OUT;

    modport master (
        output BUS_ADDR, BUS_DATA_IN, BUS_WE,
        input  BUS_DATA_OUT
    );

    modport slave (
        input  BUS_ADDR, BUS_DATA_IN, BUS_WE,
        output BUS_DATA_OUT
    );
endinterface

// File: rtl/ir_command_regs.sv
// IR drive-command registers, command validation and packet strobe timer.
// Define IR_CMD_TIMEOUT_EN to build the hold timer that returns COMMAND to IDLE.
module ir_command_regs #(
    parameter logic [7:0] BASE_ADDR     = 8'h90,
    parameter int         STROBE_PERIOD = 10_000_000,
    parameter int         STROBE_WIDTH  = 24,
    parameter int         HOLD_STROBES  = 10
) (
    input  logic               CLK,
    input  logic               RST,
    ir_command_regs_if.slave   bus,
    output logic [3:0]         COMMAND,
    output logic               pack_strobe,
    output logic               pack_gen_EN
);

    localparam logic [STROBE_WIDTH-1:0] LAST = STROBE_WIDTH'(STROBE_PERIOD - 1);

    logic [3:0]              cmd_q, cmd_d;
    logic                    en_q, en_d;
    logic                    err_q, err_d;
    logic [STROBE_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    live;

    logic [7:0] off;
    logic       hit, wr_cmd, wr_ctrl, rd, cmd_legal, strobe;
    logic       unused_din;

    assign off       = bus.BUS_ADDR - BASE_ADDR;
    assign hit       = off < 8'd3;
    assign wr_cmd    = bus.BUS_WE && hit && off[1:0] == 2'd0;
    assign wr_ctrl   = bus.BUS_WE && hit && off[1:0] == 2'd1;
    assign rd        = !bus.BUS_WE && hit;
    assign cmd_legal = !(bus.BUS_DATA_IN[3] && bus.BUS_DATA_IN[2]) &&
                       !(bus.BUS_DATA_IN[1] && bus.BUS_DATA_IN[0]);
    assign strobe    = en_q && cnt_q == LAST;
    assign unused_din = ^bus.BUS_DATA_IN[6:4];

`ifdef IR_CMD_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    assign live = hold_q != 8'd0;
`else
    assign live = 1'b0;
`endif

    always_comb begin
        cmd_d   = cmd_q;
        en_d    = en_q;
        err_d   = err_q;
        rdata_d = 8'h00;
`ifdef IR_CMD_TIMEOUT_EN
        hold_d = hold_q;
        if (strobe && hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
            if (hold_q == 8'd1) cmd_d = 4'h0;
        end
`endif
        // A bus write lands after expiry so a coincident write wins.
        if (wr_cmd) begin
            if (cmd_legal) begin
                cmd_d = bus.BUS_DATA_IN[3:0];
`ifdef IR_CMD_TIMEOUT_EN
                hold_d = 8'(HOLD_STROBES);
`endif
            end else begin
                err_d = 1'b1;
            end
        end
        if (wr_ctrl) begin
            en_d = bus.BUS_DATA_IN[0];
            if (bus.BUS_DATA_IN[7]) err_d = 1'b0;
        end
        cnt_d = (en_q && en_d && !strobe) ? cnt_q + 1'b1 : '0;
        if (rd) begin
            case (off[1:0])
                2'd0:    rdata_d = {4'h0, cmd_q};
                2'd1:    rdata_d = {7'h00, en_q};
                2'd2:    rdata_d = {cmd_q, 1'b0, err_q, live, en_q};
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmd_q   <= 4'h0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
`ifdef IR_CMD_TIMEOUT_EN
            hold_q  <= 8'h00;
`endif
        end else begin
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef IR_CMD_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign COMMAND          = cmd_q;
    assign pack_gen_EN      = en_q;
    assign pack_strobe      = strobe;
    assign bus.BUS_DATA_OUT = rdata_q;

endmodule

// File: tb/tb_ir_command_regs.sv
// Randomized and directed bench for ir_command_regs against a timeline model.
// Honors IR_CMD_TIMEOUT_EN the same way the design does.
module tb_ir_command_regs;
    localparam int P = 100;
    localparam int H = 3;
    localparam logic [7:0] BASE = 8'h90;
`ifdef IR_CMD_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] COMMAND;
    logic       pack_strobe, pack_gen_EN;

    ir_command_regs_if bus ();

    ir_command_regs #(
        .BASE_ADDR(BASE), .STROBE_PERIOD(P),
        .STROBE_WIDTH(24), .HOLD_STROBES(H)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave),
        .COMMAND(COMMAND), .pack_strobe(pack_strobe),
        .pack_gen_EN(pack_gen_EN)
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int errs = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: strobes are placed on a timeline anchored at the cycle ENABLE became visible.
    logic [3:0] m_cmd;
    bit         m_en, m_err;
    int         m_hold;
    longint     cyc, m_t0;
    logic [7:0] m_rd;

    function automatic bit m_strobe();
        return m_en && ((cyc - m_t0) % P == P - 1);
    endfunction

    function automatic bit legal(logic [3:0] c);
        return !(c[3] && c[2]) && !(c[1] && c[0]);
    endfunction

    task automatic m_reset();
        m_cmd = 4'h0; m_en = 0; m_err = 0; m_hold = 0; m_rd = 8'h00; m_t0 = 0;
    endtask

    task automatic check_outs(string tag);
        chk({tag, ":cmd"}, COMMAND, m_cmd);
        chk({tag, ":strobe"}, pack_strobe, m_strobe());
        chk({tag, ":en"}, pack_gen_EN, m_en);
        chk({tag, ":dout"}, bus.BUS_DATA_OUT, m_rd);
    endtask

    task automatic cycle(logic [7:0] a, bit we, logic [7:0] d);
        bit         s, live;
        logic [7:0] off;
        logic [3:0] ncmd;
        bit         nen, nerr;
        int         nhold;
        bus.BUS_ADDR = a; bus.BUS_WE = we; bus.BUS_DATA_IN = d;
        s = m_strobe();
        off = a - BASE;
        live = TO && m_hold != 0;
        ncmd = m_cmd; nen = m_en; nerr = m_err; nhold = m_hold;
        if (TO && s && m_hold > 0) begin
            nhold = m_hold - 1;
            if (nhold == 0) ncmd = 4'h0;
        end
        if (we && off == 8'd0) begin
            if (legal(d[3:0])) begin ncmd = d[3:0]; nhold = H; end
            else nerr = 1;
        end
        if (we && off == 8'd1) begin
            nen = d[0];
            if (d[7]) nerr = 0;
        end
        m_rd = 8'h00;
        if (!we && off == 8'd0) m_rd = {4'h0, m_cmd};
        if (!we && off == 8'd1) m_rd = {7'h00, m_en};
        if (!we && off == 8'd2) m_rd = {m_cmd, 1'b0, m_err, live, m_en};
        if (nen && !m_en) m_t0 = cyc + 1;
        m_cmd = ncmd; m_en = nen; m_err = nerr; m_hold = nhold;
        @(posedge CLK); #1;
        cyc++;
        check_outs("cyc");
    endtask

    task automatic idle(); cycle(8'h00, 0, 8'h00); endtask
    task automatic wr(int o, logic [7:0] d); cycle(BASE + 8'(o), 1, d); endtask
    task automatic rdreg(int o); cycle(BASE + 8'(o), 0, 8'h00); endtask

    task automatic do_reset();
        bus.BUS_ADDR = 8'h00; bus.BUS_WE = 0; bus.BUS_DATA_IN = 8'h00;
        RST = 1'b0;
        #1;
        m_reset();
        check_outs("rst_async");
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        cyc++;
        check_outs("rst_rel");
    endtask

    task automatic wait_strobes(int n, string tag);
        int ns = 0;
        for (int i = 0; i < (n + 1) * P && ns < n; i++) begin
            if (pack_strobe) ns++;
            idle();
        end
        chk(tag, ns, n);
    endtask

    task automatic wait_strobe_now(string tag);
        for (int i = 0; i < P + 2 && !pack_strobe; i++) idle();
        chk(tag, pack_strobe, 1'b1);
    endtask

    logic [3:0] legal_tab [9] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'hA, 4'h9, 4'h6, 4'h5};

    initial begin
        bus.BUS_ADDR = 8'h00; bus.BUS_WE = 0; bus.BUS_DATA_IN = 8'h00;
        m_reset();
        cyc = 0;
        repeat (2) @(posedge CLK);
        #1 check_outs("reset");
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK); #1;
        cyc++;
        check_outs("release");
        rdreg(2);
        chk("status_after_reset", bus.BUS_DATA_OUT, 8'h00);

        wr(1, 8'h01);
        chk("en_next_cycle", pack_gen_EN, 1'b1);
        repeat (99) idle();
        chk("first_strobe", pack_strobe, 1'b1);
        idle();
        chk("strobe_width", pack_strobe, 1'b0);
        repeat (99) idle();
        chk("second_strobe", pack_strobe, 1'b1);

        wr(0, 8'h0A);
        chk("legal_cmd", COMMAND, 4'hA);
        rdreg(2);
        chk("status_legal", bus.BUS_DATA_OUT, TO ? 8'hA3 : 8'hA1);

        wr(0, 8'h0C);
        chk("illegal_keeps", COMMAND, 4'hA);
        rdreg(2);
        chk("err_set", bus.BUS_DATA_OUT[2], 1'b1);
        wr(1, 8'h81);
        rdreg(2);
        chk("err_clr", bus.BUS_DATA_OUT[2], 1'b0);
        chk("en_kept", bus.BUS_DATA_OUT[0], 1'b1);

        wr(0, 8'h08);
        wait_strobes(3, "three_strobes");
        chk("timeout_cmd", COMMAND, TO ? 4'h0 : 4'h8);

        wr(0, 8'h05);
        wait_strobes(2, "two_strobes");
        wait_strobe_now("third_strobe");
        wr(0, 8'h06);
        chk("write_on_expiry", COMMAND, 4'h6);
        rdreg(2);
        chk("live_kept", bus.BUS_DATA_OUT[1], TO);

        wait_strobe_now("strobe_for_clear");
        wr(1, 8'h00);
        chk("clear_on_strobe_en", pack_gen_EN, 1'b0);
        wr(1, 8'h01);
        repeat (99) idle();
        chk("reenable_strobe", pack_strobe, 1'b1);

        repeat (50) idle();
        do_reset();
        chk("rst_cmd", COMMAND, 4'h0);
        wr(1, 8'h01);
        repeat (99) idle();
        chk("strobe_after_rst", pack_strobe, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            int         k;
            logic [7:0] a, d;
            bit         we;
            k  = $urandom_range(0, 5);
            a  = (k < 4) ? BASE + 8'(k) : 8'($urandom);
            we = $urandom_range(0, 3) == 0;
            d  = 8'($urandom);
            if (k == 0 && $urandom_range(0, 3) != 0) d = {4'h0, legal_tab[$urandom_range(0, 8)]};
            if (k == 1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle(a, we, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ir_command_regs.md
# ir_command_regs

Processor-bus peripheral that sits directly upstream of the IR transmitter state machine. It holds the drive command written by the processor, validates it, and generates the `COMMAND`, `pack_strobe` and `pack_gen_EN` signals the transmitter consumes. A free-running strobe timer sets the packet rate. An optional hold timer returns the car to IDLE if the processor stops refreshing the command.

## Interface
Parameters:
- `BASE_ADDR`, 8'h90: bus base address; the block decodes offsets 0–2.
- `STROBE_PERIOD`, 10_000_000: CLK cycles between `pack_strobe` pulses (10 Hz at 100 MHz); legal range 2 to 2^`STROBE_WIDTH`.
- `STROBE_WIDTH`, 24: width of the strobe counter.
- `HOLD_STROBES`, 10: number of strobes a written command stays live (timeout build only); legal range 1–255.

Ports:
- `CLK`, in, 1: system clock; all logic on the rising edge.
- `RST`, in, 1: reset, asynchronous assert, active-low; clears all state.
- `BUS_ADDR`, in, 8: processor address.
- `BUS_DATA_IN`, in, 8: processor write data.
- `BUS_WE`, in, 1: write enable; a write is one cycle with an address hit.
- `BUS_DATA_OUT`, out, 8: registered read data; 0 when not addressed.
- `COMMAND`, out, 4: drive command {F,B,L,R} to the transmitter.
- `pack_strobe`, out, 1: one-cycle packet strobe.
- `pack_gen_EN`, out, 1: transmitter enable.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0 CMD, R/W, bits[3:0].
  - 1 CTRL, R/W: bit0 ENABLE; writing 1 to bit7 clears ERR (bit7 is self-clearing and reads 0).
  - 2 STATUS, RO: bit0 ENABLE, bit1 LIVE (hold count nonzero), bit2 ERR, bits[7:4] current `COMMAND`.
  - Other offsets: writes are ignored and reads return 0.
- CMD validation:
  - Legal codes: 0000, 1000, 0100, 0010, 0001, 1010, 1001, 0110, 0101.
  - A legal write loads CMD and, in the timeout build, reloads the hold counter with `HOLD_STROBES`.
  - An illegal code (F&B both set or L&R both set) leaves CMD unchanged and sets sticky ERR.
  - Writing 0000 is legal and loads IDLE.
- Strobe timer:
  - While ENABLE=1, the counter counts 0 to `STROBE_PERIOD`-1 and wraps to 0.
  - `pack_strobe`=1 for exactly the cycle in which the count equals `STROBE_PERIOD`-1.
  - While ENABLE=0, the counter is held at 0 and no strobes are produced.
- Hold timer (timeout build only):
  - Decrements by 1 on each `pack_strobe` while nonzero.
  - When it reaches 0, CMD is forced to 0000; ERR is not affected.
- Outputs: `COMMAND` = CMD register; `pack_gen_EN` = ENABLE.

## Timing
- Reset values: `COMMAND`=0, `pack_strobe`=0, `pack_gen_EN`=0, `BUS_DATA_OUT`=0, ERR=0, hold=0, strobe count=0.
- Write latency: a write in cycle n is visible on `COMMAND`/`pack_gen_EN` in cycle n+1.
- Read latency: 1 cycle. An address hit with `BUS_WE`=0 in cycle n drives `BUS_DATA_OUT` in cycle n+1; otherwise it returns 0 in n+1.
- First strobe: ENABLE written 1 in cycle n gives the first `pack_strobe` in cycle n+`STROBE_PERIOD`.
- ENABLE cleared on the same cycle as a strobe: that strobe still fires, and the counter is 0 next cycle.
- CMD write coinciding with a hold decrement: the reload wins, so hold = `HOLD_STROBES`.
- CMD write coinciding with expiry to IDLE: the write wins.
- Illegal write coinciding with an ERR clear: ERR ends at 1 (set wins).
- Reset mid-count: the strobe counter restarts from 0; no partial strobe is produced.

## Configuration
- `IR_CMD_TIMEOUT_EN` defined:
  - The hold counter is built in.
  - `COMMAND` reverts to IDLE after `HOLD_STROBES` strobes without a legal CMD write.
  - STATUS bit1 reflects LIVE.
- `IR_CMD_TIMEOUT_EN` undefined:
  - No hold counter.
  - CMD persists until overwritten or reset.
  - STATUS bit1 reads 0.

## Test plan
All scenarios use `STROBE_PERIOD`=100, `HOLD_STROBES`=3.
- Reset: release `RST` -> all outputs 0; a read of offset 2 returns 8'h00.
- Enable: write CTRL=8'h01 at cycle 10 -> `pack_gen_EN`=1 at cycle 11; `pack_strobe` pulses at cycles 110, 210, 310, each 1 cycle wide; ENABLE=0 stops pulses after the next cycle.
- Legal command: write CMD=8'h0A -> `COMMAND`=4'b1010 next cycle; a STATUS read returns 8'hA3 (timeout build).
- Illegal command: write CMD=8'h0C while `COMMAND`=1010 -> `COMMAND` stays 1010, STATUS bit2=1; a CTRL write of 8'h81 clears ERR and keeps ENABLE=1.
- Timeout (timeout build): write 1000, then no writes -> `COMMAND` returns to 0000 the cycle after the 3rd strobe. In the non-timeout build it stays 1000.
- Simultaneous events: write CMD on the exact cycle of the 3rd strobe -> `COMMAND` equals the new value and LIVE stays 1; assert `RST` mid-period -> outputs clear immediately and the next strobe comes `STROBE_PERIOD` cycles after ENABLE is rewritten.
